nibble_stack: RTL
=================

// Module: nibble_stack
// PURPOSE
//  Operand stack for the stack calculator core; sits directly downstream of the
//  core's mode/input-select logic. Each clk applies one 3-bit stack command to
//  in_word. Exposes top two entries combinationally for ALU, 7-seg and OUTL/OUTH.
//  Shift-register storage: entry 0 = top; unused entries hold 0.
// PARAMETERS
//  WIDTH  4  bits per entry
//  DEPTH  8  number of entries (>=2)
// PORTS
//  clk          in   1                  clock, all state updates on posedge
//  rst          in   1                  synchronous reset, active-high
//  mode         in   3                  stack command (codes below)
//  in_word      in   WIDTH              data for PUSH/ROLL/ROLL2
//  top_word     out  WIDTH              entry 0 (0 when empty)
//  second_word  out  WIDTH              entry 1 (0 when count<2)
//  count        out  $clog2(DEPTH+1)    number of valid entries
//  empty        out  1                  count==0
//  full         out  1                  count==DEPTH
//  overflow     out  1                  sticky error flag (NIBBLE_STACK_ERR_EN only)
//  underflow    out  1                  sticky error flag (NIBBLE_STACK_ERR_EN only)
// BEHAVIOUR
//  - Reset: clk, rst synchronous active-high; rst has priority over mode.
//    All entries, count, overflow, underflow <= 0; empty=1, full=0.
//  - Mode codes equal the STACK_MODE_* defines in constants.v:
//    000 IDLE   hold.
//    001 PUSH   e[i+1]<=e[i], e0<=in_word, count+1. Full: e[DEPTH-1] lost,
//               count holds DEPTH, overflow set.
//    010 POP    e[i]<=e[i+1], e[DEPTH-1]<=0, count-1. Empty: no change,
//               underflow set.
//    011 SWAP   e0<->e1, count unchanged. count<2: no change, underflow set.
//    100 ROLL   e0<=in_word (replace top). Empty: count<=1, underflow set.
//    101 ROLL2  drop two, push in_word: e0<=in_word, e[i]<=e[i+1] for i>=1,
//               e[DEPTH-1]<=0, count-1. count<2: e0<=in_word, e1..<=0,
//               count<=1, underflow set.
//    110 RESET  same effect as rst (flags also cleared).
//    111 --     treated as IDLE.
//  - Latency: command takes effect at the posedge it is sampled; outputs
//    combinational from registers, valid the following cycle. One command/clk,
//    back-to-back commands allowed; no handshake.
//  - in_word sampled same edge as mode; core must present selected source that cycle.
//  - Invariant: entries at index >= count are always 0.
//  - count width arithmetic: no wrap; saturates at 0 and DEPTH as above.
// CONFIGURATION
//  NIBBLE_STACK_ERR_EN defined: overflow/underflow ports exist; set on the
//    error conditions above, remain 1 until rst or RESET mode.
//  Not defined: ports absent, error conditions apply the same data/count
//    behaviour silently. Data path identical in both builds.
// TESTING
//  1 rst, then PUSH 3, PUSH 5 -> top=5, second=3, count=2, empty=0.
//  2 from 1: SWAP -> top=3, second=5; ROLL in=A -> top=A, second=5, count=2.
//  3 from 2: ROLL2 in=F -> top=F, second=0, count=1; POP -> empty=1, top=0.
//  4 PUSH 1..8 (DEPTH=8) then PUSH 9 -> top=9, e7=2, count=8, full=1,
//    overflow=1 (ERR_EN); POP x8 -> empty, POP again -> no change, underflow=1.
//  5 SWAP with count=1 (top=7) -> top=7 unchanged, underflow=1; mode=110 ->
//    all zero, flags 0.
//  6 mode=PUSH with rst=1 -> reset wins: count=0; mode=111 -> state held.

Source files
------------

// File: rtl/nibble_stack.sv
// Shift-register operand stack: one 3-bit command per clock, top two entries exposed combinationally.
// Optional sticky overflow/underflow ports are enabled with the NIBBLE_STACK_ERR_EN macro.
module nibble_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 mode,
    input  logic [WIDTH-1:0]           in_word,
    output logic [WIDTH-1:0]           top_word,
    output logic [WIDTH-1:0]           second_word,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
`ifdef NIBBLE_STACK_ERR_EN
    output logic                       overflow,
    output logic                       underflow,
`endif
    output logic                       full
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] MODE_IDLE  = 3'b000;
    localparam logic [2:0] MODE_PUSH  = 3'b001;
    localparam logic [2:0] MODE_POP   = 3'b010;
    localparam logic [2:0] MODE_SWAP  = 3'b011;
    localparam logic [2:0] MODE_ROLL  = 3'b100;
    localparam logic [2:0] MODE_ROLL2 = 3'b101;
    localparam logic [2:0] MODE_RESET = 3'b110;

    logic [WIDTH-1:0] e_q [DEPTH];
    logic [WIDTH-1:0] e_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_set, unf_set, clr;

    always_comb begin
        e_d     = e_q;
        count_d = count_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        clr     = 1'b0;
        case (mode)
            MODE_PUSH: begin
                // When full the bottom entry falls off and count stays at DEPTH.
                for (int i = DEPTH-1; i >= 1; i--) e_d[i] = e_q[i-1];
                e_d[0] = in_word;
                if (count_q == DEPTH_C) ovf_set = 1'b1;
                else count_d = count_q + CW'(1);
            end
            MODE_POP: begin
                if (count_q == '0) begin
                    unf_set = 1'b1;
                end else begin
                    for (int i = 0; i < DEPTH-1; i++) e_d[i] = e_q[i+1];
                    e_d[DEPTH-1] = '0;
                    count_d = count_q - CW'(1);
                end
            end
            MODE_SWAP: begin
                if (count_q < CW'(2)) begin
                    unf_set = 1'b1;
                end else begin
                    e_d[0] = e_q[1];
                    e_d[1] = e_q[0];
                end
            end
            MODE_ROLL: begin
                e_d[0] = in_word;
                if (count_q == '0) begin
                    count_d = CW'(1);
                    unf_set = 1'b1;
                end
            end
            MODE_ROLL2: begin
                e_d[0] = in_word;
                if (count_q < CW'(2)) begin
                    for (int i = 1; i < DEPTH; i++) e_d[i] = '0;
                    count_d = CW'(1);
                    unf_set = 1'b1;
                end else begin
                    for (int i = 1; i < DEPTH-1; i++) e_d[i] = e_q[i+1];
                    e_d[DEPTH-1] = '0;
                    count_d = count_q - CW'(1);
                end
            end
            MODE_RESET: clr = 1'b1;
            MODE_IDLE:  ;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < DEPTH; i++) e_q[i] <= '0;
            count_q <= '0;
        end else begin
            e_q     <= e_d;
            count_q <= count_d;
        end
    end

`ifdef NIBBLE_STACK_ERR_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | ovf_set;
            unf_q <= unf_q | unf_set;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    // Error conditions still steer data/count above; only the flags are dropped.
    logic unused_err;
    assign unused_err = ovf_set | unf_set;
`endif

    assign top_word    = e_q[0];
    assign second_word = e_q[1];
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_C);
endmodule
